// File: rtl/fifo_pacer_pkg.sv
// Shared definitions for the FIFO drain pacer.
// Holds the default word and gap-setting widths, the transfer counter width,
// and the controller state encoding.
package fifo_pacer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_GAP_WIDTH  = 4;
  localparam int unsigned XFER_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapt,
    StPresent,
    StGap
  } pacer_state_e;

endpackage

// File: rtl/fifo_drain_pacer_if.sv
// Handshake bundle between the upstream FIFO, the gap configuration, the pacer
// and the downstream consumer.
//   enable, fifo_empty, fifo_data, gap_cfg, out_ready : into the pacer
//   fifo_rd_en, out_valid, out_data, xfer_count, busy  : out of the pacer
// The master modport is the environment side; the slave modport is the pacer.
interface fifo_drain_pacer_if
  import fifo_pacer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH
);

  logic                      enable;
  logic                      fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_data;
  logic                      fifo_rd_en;
  logic [GAP_WIDTH-1:0]      gap_cfg;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [XFER_CNT_WIDTH-1:0] xfer_count;
  logic                      busy;

  modport master (
    output enable, fifo_empty, fifo_data, gap_cfg, out_ready,
    input  fifo_rd_en, out_valid, out_data, xfer_count, busy
  );

  modport slave (
    input  enable, fifo_empty, fifo_data, gap_cfg, out_ready,
    output fifo_rd_en, out_valid, out_data, xfer_count, busy
  );

endinterface

// File: rtl/pacer_gap_counter.sv
// Down-counter that times the idle gap after each output transfer.
//   clk, rst     : clock and asynchronous active-high reset
//   load_i       : load load_val_i (takes priority over decrement)
//   load_val_i   : gap length to load
//   dec_i        : decrement by one while non-zero
//   value_o      : current count
//   done_o       : count equals one, i.e. the final gap cycle
module pacer_gap_counter
  import fifo_pacer_pkg::*;
#(
  parameter int unsigned GAP_WIDTH = DEF_GAP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [GAP_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic [GAP_WIDTH-1:0] value_o,
  output logic                 done_o
);

  logic [GAP_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q == GAP_WIDTH'(1));

endmodule

// File: rtl/fifo_drain_pacer.sv
// Drains an upstream FIFO one word at a time and presents each word on a
// valid/ready output, inserting gap_cfg idle cycles after every transfer.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of fifo_drain_pacer_if (FIFO read port, gap
//              setting, output handshake, transfer count and busy flag)
// out_valid, out_data and xfer_count are registered; fifo_rd_en and busy
// are decoded from the state register alone.
module fifo_drain_pacer
  import fifo_pacer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  fifo_drain_pacer_if.slave  bus
);

  pacer_state_e              state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [XFER_CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  logic                      gap_load;
  logic                      gap_done;
  logic [GAP_WIDTH-1:0]      gap_value;
  logic                      xfer;

  // out_valid_q is only ever set while presenting, so this is the transfer edge.
  assign xfer = out_valid_q && bus.out_ready;

  pacer_gap_counter #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (bus.gap_cfg),
    .dec_i      (state_q == StGap),
    .value_o    (gap_value),
    .done_o     (gap_done)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    xfer_count_d = xfer_count_q;
    gap_load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable && !bus.fifo_empty) begin
          state_d = StReq;
        end
      end
      StReq: begin
        state_d = StCapt;
      end
      StCapt: begin
        out_data_d  = bus.fifo_data;
        out_valid_d = 1'b1;
        state_d     = StPresent;
      end
      StPresent: begin
        if (xfer) begin
          out_valid_d  = 1'b0;
          xfer_count_d = xfer_count_q + 1'b1;
          if (bus.gap_cfg == '0) begin
            state_d = StIdle;
          end else begin
            gap_load = 1'b1;
            state_d  = StGap;
          end
        end
      end
      StGap: begin
        // A zero count here cannot arise from a load; treat it as finished
        // rather than stalling forever.
        if (gap_done || (gap_value == '0)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.fifo_rd_en = (state_q == StReq);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_drain_pacer.sv
// Scoreboard bench for fifo_drain_pacer. Words pushed into the modelled
// upstream FIFO are queued as expected output; a monitor pops and compares on
// every output transfer and checks latency, hold, spacing and the count.
module tb_fifo_drain_pacer;
  import fifo_pacer_pkg::*;

  localparam int DW = 4;
  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_drain_pacer_if #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) bus ();

  fifo_drain_pacer #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            rd_cycs[$];

  int cyc = 0, n_rd = 0, n_xfer = 0, model_cnt = 0;
  int last_rd_cyc = 0, last_x_cyc = 0, last_gap = 0;
  bit have_x = 0, pend = 0, prev_valid = 0, prev_stall = 0;
  logic [DW-1:0] prev_data, last_exp;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int req);
    chk(act == req, name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // Upstream FIFO: registered read data, updated away from the DUT edge.
  always @(negedge clk) begin
    if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    if (rst) begin
      prev_valid = 0; prev_stall = 0; pend = 0; have_x = 0; model_cnt = 0;
    end else begin
      if (pend) begin
        chk_eq("xfer_count", bus.xfer_count, model_cnt);
        chk_eq("valid_drop", bus.out_valid, 0);
        chk_eq("data_hold", bus.out_data, last_exp);
        pend = 0;
      end
      if (bus.fifo_rd_en) begin
        n_rd++;
        if (have_x) chk(cyc >= last_x_cyc + last_gap + 2, "rd_spacing",
                        cyc - last_x_cyc, last_gap + 2);
        rd_cycs.push_back(cyc);
        last_rd_cyc = cyc;
      end
      if (bus.out_valid && !prev_valid) chk_eq("latency", cyc - last_rd_cyc, 2);
      if (bus.out_valid && prev_stall) chk_eq("data_stable", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_xfer", bus.out_data, -1);
        end else begin
          e = exp_q.pop_front();
          chk_eq("out_data", bus.out_data, e);
          last_exp = e;
        end
        model_cnt  = (model_cnt + 1) % 256;
        pend       = 1;
        have_x     = 1;
        last_x_cyc = cyc;
        last_gap   = bus.gap_cfg;
      end
      prev_valid = bus.out_valid;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic wait_idle(input int limit, input bit rnd);
    bit done = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (rnd) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.gap_cfg   = GW'($urandom_range(0, 2));
      end
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.busy) begin
        done = 1;
        break;
      end
    end
    chk(done, "idle_timeout", done, 1);
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic wait_valid(input int limit);
    bit done = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        done = 1;
        break;
      end
    end
    chk(done, "valid_timeout", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    chk_eq({tag, "_valid"}, bus.out_valid, 0);
    chk_eq({tag, "_data"}, bus.out_data, 0);
    chk_eq({tag, "_count"}, bus.xfer_count, 0);
    chk_eq({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    bus.enable = 1'b1; bus.fifo_empty = 1'b1; bus.fifo_data = '0;
    bus.gap_cfg = '0; bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Single word, no gap.
    rd_cycs.delete();
    push(4'hA);
    wait_idle(50, 0);
    chk_eq("s1_rd_pulses", rd_cycs.size(), 1);
    chk_eq("s1_count", bus.xfer_count, 1);

    // Three words, gap of three: reads seven cycles apart.
    bus.gap_cfg = 4'd3;
    rd_cycs.delete();
    push(4'h1); push(4'h2); push(4'h3);
    wait_idle(100, 0);
    chk_eq("s2_rd_pulses", rd_cycs.size(), 3);
    if (rd_cycs.size() == 3) begin
      chk_eq("s2_spacing_a", rd_cycs[1] - rd_cycs[0], 7);
      chk_eq("s2_spacing_b", rd_cycs[2] - rd_cycs[1], 7);
    end
    chk_eq("s2_count", bus.xfer_count, 4);

    // Downstream stall: word held, no further reads.
    bus.gap_cfg = '0;
    bus.out_ready = 1'b0;
    push(4'h5); push(4'h6);
    wait_valid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("s3_valid", bus.out_valid, 1);
      chk_eq("s3_data", bus.out_data, 5);
      chk_eq("s3_no_rd", bus.fifo_rd_en, 0);
    end
    step();
    bus.out_ready = 1'b1;
    wait_idle(100, 0);

    // Reset while capturing: word is lost, nothing is re-read.
    push(4'h7);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "s4_rd_timeout", ok, 1);
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("s4");
    for (int i = n_xfer; i < n_rd; i++) void'(exp_q.pop_front());
    n_xfer = n_rd;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_eq("s4_no_rd", bus.fifo_rd_en, 0);
    end
    chk_eq("s4_busy", bus.busy, 0);

    // Enable dropped while presenting: word completes, next read waits.
    step();
    bus.out_ready = 1'b0;
    push(4'h8); push(4'h9);
    wait_valid(50);
    step();
    bus.enable = 1'b0;
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_eq("s5_no_rd", bus.fifo_rd_en, 0);
    end
    chk_eq("s5_busy", bus.busy, 0);
    chk_eq("s5_count", bus.xfer_count, 1);
    step();
    bus.enable = 1'b1;
    wait_idle(100, 0);
    chk_eq("s5_count2", bus.xfer_count, 2);

    // Random traffic up to 256 transfers since reset: count wraps to zero.
    for (int i = 0; i < 254; i++) push(DW'($urandom));
    wait_idle(20000, 1);
    chk_eq("s6_wrap", bus.xfer_count, 0);
    chk_eq("s6_model", bus.xfer_count, model_cnt);
    chk_eq("s6_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_pacer.md
FIFO_DRAIN_PACER -- requirements
Module: fifo_drain_pacer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, the FIFO word width.
REQ-002 The block SHALL have parameter GAP_WIDTH, default 4, the width of the inter-read gap setting.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 `clk  input  1` SHALL be the single clock; all state updates on its rising edge.
REQ-005 `rst  input  1` SHALL be the asynchronous reset, active-high.
REQ-006 `enable  input  1` SHALL allow new FIFO reads when high.
REQ-007 `fifo_empty  input  1` SHALL be the upstream FIFO empty flag.
REQ-008 `fifo_data  input  DATA_WIDTH` SHALL be the upstream FIFO registered read data.
REQ-009 `fifo_rd_en  output  1` SHALL be the read strobe to the upstream FIFO.
REQ-010 `gap_cfg  input  GAP_WIDTH` SHALL set the idle cycles inserted after each output transfer.
REQ-011 `out_valid  output  1` SHALL flag that out_data holds an untransferred word.
REQ-012 `out_ready  input  1` SHALL be the downstream accept signal.
REQ-013 `out_data  output  DATA_WIDTH` SHALL be the word presented downstream.
REQ-014 `xfer_count  output  8` SHALL count completed output transfers.
REQ-015 `busy  output  1` SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have five states: IDLE, REQ, CAPT, PRESENT and GAP.
REQ-017 IDLE SHALL go to REQ on an edge where enable=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-018 fifo_empty and enable SHALL be sampled only in IDLE.
REQ-019 fifo_rd_en SHALL be 1 exactly while in REQ (one cycle per read) and 0 in every other state.
REQ-020 REQ SHALL go to CAPT unconditionally.
REQ-021 In CAPT, fifo_data SHALL be valid; on the edge leaving CAPT, out_data SHALL load fifo_data and the FSM SHALL go to PRESENT.
REQ-022 In PRESENT, out_valid SHALL be 1 and out_data SHALL be held stable until transfer.
REQ-023 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-024 On a transfer, xfer_count SHALL increment, wrapping 255 -> 0.
REQ-025 On a transfer with gap_cfg=0, the FSM SHALL go to IDLE.
REQ-026 On a transfer with gap_cfg=N>0, the gap counter SHALL load N, the FSM SHALL go to GAP, and gap_cfg SHALL be sampled only at that edge.
REQ-027 In GAP, the counter SHALL decrement each cycle; the FSM SHALL go to IDLE on the edge where the counter equals 1, giving exactly N GAP cycles.
REQ-028 Latency SHALL be: IDLE with fifo_empty=0 at cycle t -> fifo_rd_en at t+1 -> out_valid at t+3.
REQ-029 With out_ready held high, the minimum read-to-read spacing SHALL be 4+gap_cfg cycles.
REQ-030 After a transfer, out_valid SHALL drop the next cycle, and out_data SHALL keep the last transferred value.
REQ-031 out_ready while out_valid=0 SHALL be ignored.
REQ-032 enable going low SHALL NOT abort a read in progress; the current word still completes PRESENT.
REQ-033 enable going low SHALL only block the next IDLE -> REQ transition.
REQ-034 A gap_cfg change outside the transfer edge SHALL NOT affect a GAP already in progress.

Reset
REQ-035 When rst=1, the block SHALL asynchronously force state=IDLE, fifo_rd_en=0, out_valid=0, out_data=0, xfer_count=0, busy=0 and gap counter=0.
REQ-036 Reset in REQ, CAPT or PRESENT SHALL discard the in-flight word with no retry; the upstream read is lost.
REQ-037 After rst deasserts, the first read SHALL be no earlier than the first edge on which IDLE sees fifo_empty=0.

Structure
REQ-038 Package fifo_pacer_pkg SHALL hold the state enumeration and the default DATA_WIDTH/GAP_WIDTH constants.
REQ-039 The gap down-counter SHALL be sub-module pacer_gap_counter, with load, value and done (count==1) ports.
REQ-040 All outputs SHALL be registered, except fifo_rd_en and busy, which SHALL be decoded from the state register only.

Verification
REQ-041 Scenario 1: FIFO holds 0xA, enable=1, out_ready=1, gap_cfg=0 -> fifo_rd_en pulses 1 cycle, out_valid at t+3 with out_data=0xA, xfer_count=1.
REQ-042 Scenario 2: FIFO holds 0x1,0x2,0x3, gap_cfg=3, out_ready=1 -> three transfers, rd_en pulses 7 cycles apart, xfer_count=3.
REQ-043 Scenario 3: out_ready=0 for 5 cycles after out_valid -> out_data=0x5 held stable, no further rd_en; transfer on the cycle ready rises.
REQ-044 Scenario 4: rst asserted in CAPT -> all outputs 0 immediately; after release with fifo_empty=1, no rd_en.
REQ-045 Scenario 5: enable dropped in PRESENT -> the word still transfers, FSM returns to IDLE, no new rd_en until enable=1.
REQ-046 Scenario 6: 256 transfers -> xfer_count wraps to 0.
